// File: rtl/stoch_monitor_ctrl_if.sv
// Bundles the measurement control, stochastic inputs and result stream of stoch_monitor_ctrl.
// The slave modport is the monitor controller; the master modport is the host/readout side.
interface stoch_monitor_ctrl_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int WIN_WIDTH = 16,
    parameter int CH_WIDTH  = 2
);
    logic                 start;
    logic [WIN_WIDTH-1:0] window_len;
    logic                 abort;
    logic [NUM_CH-1:0]    a;
    logic                 busy;
    logic                 res_valid;
    logic                 res_ready;
    logic [CH_WIDTH-1:0]  res_ch;
    logic [CNT_WIDTH-1:0] res_count;
    logic                 res_sat;
    logic                 done;
    logic [1:0]           dbg_state;

    modport slave (
        input  start, window_len, abort, a, res_ready,
        output busy, res_valid, res_ch, res_count, res_sat, done, dbg_state
    );

    modport master (
        output start, window_len, abort, a, res_ready,
        input  busy, res_valid, res_ch, res_count, res_sat, done, dbg_state
    );
endinterface

// File: rtl/stoch_monitor_ctrl.sv
// Counts ones on NUM_CH stochastic bitstreams over a window_len-clock window, then streams
// the per-channel counts (with sticky saturation flags) out in channel order.
module stoch_monitor_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int WIN_WIDTH = 16,
    parameter int CH_WIDTH  = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    stoch_monitor_ctrl_if.slave     bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CH_WIDTH-1:0]  LAST_CH = CH_WIDTH'(NUM_CH - 1);
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];
    logic [NUM_CH-1:0]    r_sat;
    logic [WIN_WIDTH-1:0] r_remaining;
    logic [CH_WIDTH-1:0]  r_ch_idx;
    logic                 r_done;
    logic                 w_drain;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_sat       <= '0;
            r_remaining <= '0;
            r_ch_idx    <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_sat       <= '0;
                            r_remaining <= bus.window_len;
                            r_ch_idx    <= '0;
                            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
                            r_state     <= (bus.window_len != '0) ? RUN : DRAIN;
                        end
                    end
                    RUN: begin
                        // Saturated counters hold at all-ones; the sat flag stays set for the window.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (bus.a[i]) begin
                                if (&r_cnt[i]) r_sat[i] <= 1'b1;
                                else           r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == WIN_ONE) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        // Result handshake: a word transfers on any edge where res_valid and
                        // res_ready are both high; while res_ready is low the word is held unchanged.
                        if (bus.res_ready) begin
                            if (r_ch_idx == LAST_CH) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_ch_idx <= r_ch_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_drain       = (r_state == DRAIN);
    assign bus.busy      = (r_state != IDLE);
    assign bus.res_valid = w_drain;
    assign bus.res_ch    = w_drain ? r_ch_idx : '0;
    assign bus.res_count = w_drain ? r_cnt[r_ch_idx] : '0;
    assign bus.res_sat   = w_drain ? r_sat[r_ch_idx] : 1'b0;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_stoch_monitor_ctrl.sv
// Randomized scoreboard bench for stoch_monitor_ctrl; expected words come from per-window
// ones tallies clipped at the counter maximum.
module tb_stoch_monitor_ctrl;
  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 4;
  localparam int WIN_WIDTH = 8;
  localparam int CH_WIDTH  = 2;
  localparam int W         = CH_WIDTH + CNT_WIDTH + 1;
  localparam int MAXC      = (1 << CNT_WIDTH) - 1;

  logic CLK;
  logic nRST;

  stoch_monitor_ctrl_if #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .WIN_WIDTH(WIN_WIDTH), .CH_WIDTH(CH_WIDTH)
  ) smc ();

  stoch_monitor_ctrl #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .WIN_WIDTH(WIN_WIDTH), .CH_WIDTH(CH_WIDTH)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (smc)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit pend   = 0;
  int rdy_mode = 0;
  int rdy_cyc  = 0;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] gen_a(input int amode, input int k);
    logic [NUM_CH-1:0] v;
    case (amode)
      1:       v = (k < 8) ? 4'b0101 : 4'b1111;
      2:       v = 4'b0001;
      default: v = NUM_CH'($urandom);
    endcase
    return v;
  endfunction

  // ready driver
  initial begin
    smc.res_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      rdy_cyc++;
      case (rdy_mode)
        0:       smc.res_ready = 1'b1;
        1:       smc.res_ready = 1'($urandom_range(0, 1));
        2:       smc.res_ready = (rdy_cyc < 5) ? 1'b0 : rdy_cyc[0];
        default: smc.res_ready = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge CLK);
      if (pend || smc.done) begin
        check("done_after_last_word", 32'(smc.done), 32'(pend));
        pend = 0;
      end
      if (smc.res_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got ch=%0d count=%0d sat=%0d, none expected at %0t",
                   smc.res_ch, smc.res_count, smc.res_sat, $time);
        end else begin
          check("result_word", 32'({smc.res_ch, smc.res_count, smc.res_sat}), 32'(exp_q[0]));
          if (smc.res_ready) begin
            if (exp_q[0][W-1 -: CH_WIDTH] == CH_WIDTH'(NUM_CH - 1)) pend = 1;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("outputs_zero_outside_drain", 32'({smc.res_ch, smc.res_count, smc.res_sat}), 32'(0));
      end
    end
  end

  // driver tasks
  task automatic start_and_run(input int w, input int amode, input bit poke);
    int ones [NUM_CH];
    logic [NUM_CH-1:0] av;
    int cnt;
    foreach (ones[c]) ones[c] = 0;
    smc.window_len = WIN_WIDTH'(w);
    smc.start      = 1'b1;
    smc.a          = '1;
    @(posedge CLK);
    #1;
    smc.start      = 1'b0;
    smc.window_len = WIN_WIDTH'($urandom);
    for (int k = 0; k < w; k++) begin
      av = gen_a(amode, k);
      smc.a = av;
      for (int c = 0; c < NUM_CH; c++) ones[c] += int'(av[c]);
      smc.start = poke && (k == 1);
      smc.window_len = WIN_WIDTH'($urandom_range(1, 3));
      @(negedge CLK);
      check("busy_in_run", 32'(smc.busy), 32'(1));
      check("no_valid_in_run", 32'(smc.res_valid), 32'(0));
      @(posedge CLK);
      #1;
      smc.start = 1'b0;
    end
    smc.a = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt = (ones[c] > MAXC) ? MAXC : ones[c];
      exp_q.push_back({CH_WIDTH'(c), CNT_WIDTH'(cnt), ones[c] > MAXC});
    end
  endtask

  task automatic finish_drain(input bit poke, input int dmode);
    bit seen;
    if (dmode == 2) begin
      rdy_mode = 2;
      rdy_cyc = 0;
      smc.res_ready = 1'b0;
    end
    if (poke) begin
      smc.start = 1'b1;
      smc.window_len = WIN_WIDTH'(5);
      @(posedge CLK);
      #1;
      smc.start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      seen = smc.done;
    end
    check("done_seen_within_budget", 32'(seen), 32'(1));
    if (seen) check("busy_low_in_done_cycle", 32'(smc.busy), 32'(0));
  endtask

  initial begin
    bit chain;
    int w;
    nRST = 1'b0;
    smc.start = 1'b0;
    smc.abort = 1'b0;
    smc.window_len = '0;
    smc.a = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busy", 32'(smc.busy), 32'(0));
    check("reset_valid", 32'(smc.res_valid), 32'(0));
    check("reset_done", 32'(smc.done), 32'(0));
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // fixed pattern window
    rdy_mode = 0;
    start_and_run(8, 1, 0);
    finish_drain(0, 0);
    @(posedge CLK); #1;

    // empty window
    start_and_run(0, 0, 0);
    finish_drain(0, 0);
    @(posedge CLK); #1;

    // saturation on channel 0
    start_and_run(20, 2, 0);
    finish_drain(0, 0);
    @(posedge CLK); #1;

    // backpressure
    start_and_run(12, 0, 0);
    finish_drain(0, 2);
    rdy_mode = 0;
    @(posedge CLK); #1;

    // ignored starts, then restart in the done cycle
    start_and_run(9, 0, 1);
    finish_drain(1, 0);
    start_and_run(6, 0, 0);
    finish_drain(0, 0);
    @(posedge CLK); #1;

    // abort in the third RUN cycle
    smc.window_len = WIN_WIDTH'(10);
    smc.start = 1'b1;
    @(posedge CLK); #1;
    smc.start = 1'b0;
    smc.a = NUM_CH'($urandom);
    repeat (2) begin @(posedge CLK); #1; end
    smc.abort = 1'b1;
    @(posedge CLK); #1;
    smc.abort = 1'b0;
    check("abort_busy_low", 32'(smc.busy), 32'(0));
    check("abort_no_valid", 32'(smc.res_valid), 32'(0));
    repeat (15) @(posedge CLK);
    #1;

    // randomized windows
    for (int n = 0; n < 15; n++) begin
      w = $urandom_range(0, 40);
      rdy_mode = $urandom_range(0, 1);
      start_and_run(w, 0, 0);
      finish_drain(0, 0);
      chain = 1'($urandom_range(0, 1));
      if (!chain || n == 14) begin
        repeat (1 + $urandom_range(0, 3)) @(posedge CLK);
        #1;
      end
    end
    rdy_mode = 0;

    // reset mid-DRAIN
    rdy_mode = 3;
    smc.res_ready = 1'b0;
    start_and_run(5, 0, 0);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({smc.busy, smc.res_valid, smc.res_ch, smc.res_count, smc.res_sat, smc.done}), 32'(0));
    exp_q.delete();
    pend = 0;
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b1;
    rdy_mode = 0;
    repeat (12) @(posedge CLK);
    #1;
    check("idle_after_reset_release", 32'(smc.busy), 32'(0));

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
